// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared types and default sizes for the line-RAM access arbiter.
package ram_arb_pkg;

  localparam int                    ARB_NUM_REQ    = 4;
  localparam int                    ARB_NUM_RAM    = 4;
  localparam int                    ARB_ADDR_W     = 16;
  localparam int                    ARB_DATA_W     = 8;
  localparam int                    ARB_RD_LAT     = 1;
  localparam logic [ARB_ADDR_W-1:0] ARB_ADDR_LIMIT = 16'h1000;

  typedef logic [1:0] ram_id_t;
  typedef logic [1:0] req_id_t;

  // One requester's payload, unpacked from the flat port vectors.
  typedef struct packed {
    logic                  we;
    ram_id_t               ram;
    logic [ARB_ADDR_W-1:0] addr;
    logic [ARB_DATA_W-1:0] wdata;
  } req_t;

  // Routing tag that travels alongside an outstanding read.
  typedef struct packed {
    logic    vld;
    req_id_t req_id;
    ram_id_t ram_id;
  } rd_tag_t;

endpackage

// File: rtl/ram_rd_return_pipe.sv
// ram_rd_return_pipe: delays per-RAM read tags by the RAM read latency, then
// captures the matching RAM dout into the requester's registered return port.
module ram_rd_return_pipe
  import ram_arb_pkg::*;
#(
  parameter int NUM_REQ = ARB_NUM_REQ,
  parameter int NUM_RAM = ARB_NUM_RAM,
  parameter int DATA_W  = ARB_DATA_W,
  parameter int RD_LAT  = ARB_RD_LAT
) (
  input  logic                      i_CLK,
  input  logic                      i_RST,
  input  rd_tag_t [NUM_RAM-1:0]     i_tag,
  input  logic [NUM_RAM*DATA_W-1:0] i_ram_dout,
  output logic [NUM_REQ-1:0]        o_rvalid,
  output logic [NUM_REQ*DATA_W-1:0] o_rdata
);

  // One lane per RAM; stage RD_LAT lines up with valid dout.
  rd_tag_t [NUM_RAM-1:0]     tag_q [RD_LAT+1];
  logic [NUM_REQ-1:0]        rvalid_nxt;
  logic [NUM_REQ*DATA_W-1:0] rdata_nxt;

  // Shift tags in step with the RAM read latency.
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      // NOTE: this is a handful of flops, not a RAM array, so it is reset;
      // a stale vld surviving reset would return data nobody asked for.
      for (int s = 0; s <= RD_LAT; s++) tag_q[s] <= '0;
    end else begin
      tag_q[0] <= i_tag;
      for (int s = 1; s <= RD_LAT; s++) tag_q[s] <= tag_q[s-1];
    end
  end

  // Route each arriving dout to the requester named in its tag.
  always_comb begin
    rvalid_nxt = '0;
    rdata_nxt  = '0;
    for (int l = 0; l < NUM_RAM; l++) begin
      if (tag_q[RD_LAT][l].vld) begin
        rvalid_nxt[tag_q[RD_LAT][l].req_id] = 1'b1;
        rdata_nxt[int'(tag_q[RD_LAT][l].req_id)*DATA_W +: DATA_W] =
          i_ram_dout[int'(tag_q[RD_LAT][l].ram_id)*DATA_W +: DATA_W];
      end
    end
  end

  // Register the return so rvalid/rdata are clean one-cycle pulses.
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      o_rvalid <= '0;
      o_rdata  <= '0;
    end else begin
      o_rvalid <= rvalid_nxt;
      o_rdata  <= rdata_nxt;
    end
  end

endmodule

// File: rtl/ram_access_arbiter.sv
// ram_access_arbiter: shares four line RAMs among the video engines. One
// round-robin pass per cycle grants any number of reads to distinct RAMs plus
// at most one write; out-of-window addresses are consumed and flagged.
module ram_access_arbiter
  import ram_arb_pkg::*;
#(
  parameter int                NUM_REQ    = ARB_NUM_REQ,
  parameter int                NUM_RAM    = ARB_NUM_RAM,
  parameter int                ADDR_W     = ARB_ADDR_W,
  parameter int                DATA_W     = ARB_DATA_W,
  parameter logic [ADDR_W-1:0] ADDR_LIMIT = ARB_ADDR_LIMIT,
  parameter int                RD_LAT     = ARB_RD_LAT
) (
  input  logic                      i_CLK,
  input  logic                      i_RST,
  input  logic [NUM_REQ-1:0]        i_req_valid,
  input  logic [NUM_REQ-1:0]        i_req_we,
  input  logic [NUM_REQ*2-1:0]      i_req_ram,
  input  logic [NUM_REQ*ADDR_W-1:0] i_req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] i_req_wdata,
  output logic [NUM_REQ-1:0]        o_req_ready,
  output logic [NUM_REQ-1:0]        o_err,
  output logic [NUM_REQ-1:0]        o_rvalid,
  output logic [NUM_REQ*DATA_W-1:0] o_rdata,
  output logic [NUM_RAM-1:0]        o_ram_cs,
  output logic [NUM_RAM-1:0]        o_ram_we,
  output logic [NUM_RAM*ADDR_W-1:0] o_ram_addr,
  output logic [NUM_RAM*DATA_W-1:0] o_ram_din,
  input  logic [NUM_RAM*DATA_W-1:0] i_ram_dout,
  output logic [15:0]               o_stall_cnt
);

  req_t                      req [NUM_REQ];
  logic [NUM_REQ-1:0]        grant;
  logic [NUM_REQ-1:0]        reject;
  logic [NUM_RAM-1:0]        claimed;
  logic                      wr_used;
  logic                      any_grant;
  req_id_t                   first_grant;
  req_id_t                   scan_idx;
  req_id_t                   rr_ptr;
  logic                      stall;
  logic [NUM_RAM-1:0]        cs_nxt;
  logic [NUM_RAM-1:0]        we_nxt;
  logic [NUM_RAM*ADDR_W-1:0] addr_nxt;
  logic [NUM_RAM*DATA_W-1:0] din_nxt;
  rd_tag_t [NUM_RAM-1:0]     tag_nxt;

  // Unpack the flat request vectors into per-requester records.
  always_comb begin
    for (int r = 0; r < NUM_REQ; r++) begin
      req[r].we    = i_req_we[r];
      req[r].ram   = i_req_ram[r*2 +: 2];
      req[r].addr  = i_req_addr[r*ADDR_W +: ADDR_W];
      req[r].wdata = i_req_wdata[r*DATA_W +: DATA_W];
    end
  end

  // Round-robin scan: reject out-of-window, else grant if RAM and write slot are free.
  always_comb begin
    // NOTE: every variable gets a default before the loop so no path through
    // this block leaves one unassigned, which would otherwise infer a latch.
    grant       = '0;
    reject      = '0;
    claimed     = '0;
    wr_used     = 1'b0;
    any_grant   = 1'b0;
    first_grant = rr_ptr;
    scan_idx    = rr_ptr;
    if (!i_RST) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        scan_idx = req_id_t'((int'(rr_ptr) + k) % NUM_REQ);
        if (i_req_valid[scan_idx]) begin
          if (req[scan_idx].addr >= ADDR_LIMIT) begin
            reject[scan_idx] = 1'b1;
          end else if (!claimed[req[scan_idx].ram] && !(req[scan_idx].we && wr_used)) begin
            grant[scan_idx]            = 1'b1;
            claimed[req[scan_idx].ram] = 1'b1;
            if (req[scan_idx].we) wr_used = 1'b1;
            if (!any_grant) begin
              any_grant   = 1'b1;
              first_grant = scan_idx;
            end
          end
        end
      end
    end
  end

  assign o_req_ready = grant | reject;
  assign stall       = |(i_req_valid & ~o_req_ready);

  // Build next-cycle RAM drive and read tags from this cycle's grants.
  always_comb begin
    cs_nxt   = '0;
    we_nxt   = '0;
    addr_nxt = '0;
    din_nxt  = '0;
    tag_nxt  = '0;
    for (int r = 0; r < NUM_REQ; r++) begin
      if (grant[r]) begin
        cs_nxt[req[r].ram] = 1'b1;
        we_nxt[req[r].ram] = req[r].we;
        addr_nxt[int'(req[r].ram)*ADDR_W +: ADDR_W] = req[r].addr;
        if (req[r].we) begin
          din_nxt[int'(req[r].ram)*DATA_W +: DATA_W] = req[r].wdata;
        end else begin
          tag_nxt[req[r].ram] = '{vld: 1'b1, req_id: req_id_t'(r), ram_id: req[r].ram};
        end
      end
    end
  end

  // Register RAM drive, error pulses, round-robin pointer and stall counter.
  always_ff @(posedge i_CLK) begin
    // NOTE: state is updated with <= so every flop samples pre-edge values;
    // the combinational blocks above use = because they describe wires.
    if (i_RST) begin
      rr_ptr      <= '0;
      o_err       <= '0;
      o_ram_cs    <= '0;
      o_ram_we    <= '0;
      o_ram_addr  <= '0;
      o_ram_din   <= '0;
      o_stall_cnt <= '0;
    end else begin
      o_err      <= reject;
      o_ram_cs   <= cs_nxt;
      o_ram_we   <= we_nxt;
      o_ram_addr <= addr_nxt;
      o_ram_din  <= din_nxt;
      if (any_grant) rr_ptr <= req_id_t'((int'(first_grant) + 1) % NUM_REQ);
      if (stall && (o_stall_cnt != 16'hFFFF)) o_stall_cnt <= o_stall_cnt + 16'd1;
    end
  end

  ram_rd_return_pipe #(
    .NUM_REQ (NUM_REQ),
    .NUM_RAM (NUM_RAM),
    .DATA_W  (DATA_W),
    .RD_LAT  (RD_LAT)
  ) u_rd_return (
    .i_CLK      (i_CLK),
    .i_RST      (i_RST),
    .i_tag      (tag_nxt),
    .i_ram_dout (i_ram_dout),
    .o_rvalid   (o_rvalid),
    .o_rdata    (o_rdata)
  );

endmodule

// File: tb/tb_ram_access_arbiter.sv
// tb_ram_access_arbiter: directed scenarios plus random traffic, checked every
// cycle against a transaction-level model of the arbitration rules.
module tb_ram_access_arbiter;

  localparam int          RD_LAT     = 1;
  localparam int          RESP_DELAY = 2 + RD_LAT;
  localparam logic [15:0] LIMIT      = 16'h1000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  i_req_valid = '0;
  logic [3:0]  i_req_we    = '0;
  logic [7:0]  i_req_ram   = '0;
  logic [63:0] i_req_addr  = '0;
  logic [31:0] i_req_wdata = '0;
  logic [3:0]  o_req_ready, o_err, o_rvalid, o_ram_cs, o_ram_we;
  logic [31:0] o_rdata, o_ram_din;
  logic [63:0] o_ram_addr;
  logic [15:0] o_stall_cnt;
  logic [31:0] ram_dout;

  always #5 clk = ~clk;

  ram_access_arbiter #(.RD_LAT(RD_LAT)) dut (
    .i_CLK       (clk),
    .i_RST       (rst),
    .i_req_valid (i_req_valid),
    .i_req_we    (i_req_we),
    .i_req_ram   (i_req_ram),
    .i_req_addr  (i_req_addr),
    .i_req_wdata (i_req_wdata),
    .o_req_ready (o_req_ready),
    .o_err       (o_err),
    .o_rvalid    (o_rvalid),
    .o_rdata     (o_rdata),
    .o_ram_cs    (o_ram_cs),
    .o_ram_we    (o_ram_we),
    .o_ram_addr  (o_ram_addr),
    .o_ram_din   (o_ram_din),
    .i_ram_dout  (ram_dout),
    .o_stall_cnt (o_stall_cnt)
  );

  function automatic logic [7:0] init_val(input int m, input int a);
    return 8'((m * 59 + a * 7 + (a >> 5)) & 255);
  endfunction

  // Four 4Kx8 synchronous RAMs with one cycle of read latency.
  logic [7:0] ram_mem [4][4096];
  initial begin
    ram_dout <= '0;
    for (int m = 0; m < 4; m++)
      for (int a = 0; a < 4096; a++) ram_mem[m][a] <= init_val(m, a);
  end
  always @(posedge clk) begin
    for (int m = 0; m < 4; m++) begin
      if (o_ram_cs[m] === 1'b1) begin
        if (o_ram_we[m]) ram_mem[m][o_ram_addr[m*16 +: 12]] <= o_ram_din[m*8 +: 8];
        else             ram_dout[m*8 +: 8] <= ram_mem[m][o_ram_addr[m*16 +: 12]];
      end
    end
  end

  // Reference model state.
  typedef struct { int due; int req; logic [7:0] data; } resp_t;
  resp_t       resp_q[$];
  logic [7:0]  ref_mem [4][4096];
  int          cyc = 0;
  int          m_rr = 0;
  logic [15:0] m_stall = '0;
  logic [3:0]  m_err = '0, m_cs = '0, m_we = '0;
  logic [63:0] m_addr = '0;
  logic [31:0] m_din = '0;
  logic [3:0]  last_ready = '0;
  int          n_cmp = 0;
  int          n_fail = 0;
  int          gcount [4];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic set_req(input int r, input bit v, input bit w, input int ram,
                         input int addr, input int wd);
    i_req_valid[r]          = v;
    i_req_we[r]             = w;
    i_req_ram[r*2 +: 2]     = 2'(ram);
    i_req_addr[r*16 +: 16]  = 16'(addr);
    i_req_wdata[r*8 +: 8]   = 8'(wd);
  endtask

  // Compare every output against the model, then apply this cycle's arbitration.
  task automatic sample();
    logic [3:0]  exp_rv, gnt, rej, taken, exp_ready;
    logic [31:0] exp_rd, din_mask;
    logic [15:0] a;
    logic        cs_ok;
    bit          wr_slot;
    int          first, m;
    resp_t       e;
    #1;
    exp_rv = '0;
    exp_rd = '0;
    foreach (resp_q[i]) begin
      if (resp_q[i].due == cyc) begin
        exp_rv[resp_q[i].req]         = 1'b1;
        exp_rd[resp_q[i].req*8 +: 8]  = resp_q[i].data;
      end
    end
    for (int i = resp_q.size() - 1; i >= 0; i--) if (resp_q[i].due == cyc) resp_q.delete(i);
    din_mask = '1;
    cs_ok    = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (m_cs[k] && !m_we[k]) din_mask[k*8 +: 8] = 8'h00;
      if (o_ram_cs[k] && (o_ram_addr[k*16 +: 16] >= LIMIT)) cs_ok = 1'b0;
    end
    check("rvalid", o_rvalid, exp_rv);
    check("rdata", o_rdata, exp_rd);
    check("err", o_err, m_err);
    check("ram_cs", o_ram_cs, m_cs);
    check("ram_we", o_ram_we, m_we);
    check("ram_addr", o_ram_addr, m_addr);
    check("ram_din", o_ram_din & din_mask, m_din & din_mask);
    check("stall_cnt", o_stall_cnt, m_stall);
    check("write_onehot0", $onehot0(o_ram_cs & o_ram_we), 1);
    check("cs_in_window", cs_ok, 1);

    gnt = '0; rej = '0; taken = '0; wr_slot = 0; first = -1;
    if (!rst) begin
      for (int k = 0; k < 4; k++) begin
        int r;
        r = (m_rr + k) % 4;
        if (!i_req_valid[r]) continue;
        a = i_req_addr[r*16 +: 16];
        m = int'(i_req_ram[r*2 +: 2]);
        if (a >= LIMIT) begin rej[r] = 1'b1; continue; end
        if (taken[m] || (i_req_we[r] && wr_slot)) continue;
        gnt[r]   = 1'b1;
        taken[m] = 1'b1;
        if (i_req_we[r]) wr_slot = 1;
        if (first < 0) first = r;
      end
    end
    exp_ready = gnt | rej;
    check("ready", o_req_ready, exp_ready);
    last_ready = exp_ready;

    if (rst) begin
      m_rr = 0; m_stall = '0; m_err = '0; m_cs = '0; m_we = '0; m_addr = '0; m_din = '0;
      resp_q.delete();
    end else begin
      m_err = rej; m_cs = '0; m_we = '0; m_addr = '0; m_din = '0;
      for (int r = 0; r < 4; r++) begin
        if (gnt[r]) begin
          a = i_req_addr[r*16 +: 16];
          m = int'(i_req_ram[r*2 +: 2]);
          m_cs[m] = 1'b1;
          m_we[m] = i_req_we[r];
          m_addr[m*16 +: 16] = a;
          if (i_req_we[r]) begin
            m_din[m*8 +: 8] = i_req_wdata[r*8 +: 8];
            ref_mem[m][a[11:0]] = i_req_wdata[r*8 +: 8];
          end else begin
            e.due = cyc + RESP_DELAY; e.req = r; e.data = ref_mem[m][a[11:0]];
            resp_q.push_back(e);
          end
        end
      end
      if (first >= 0) m_rr = (first + 1) % 4;
      if (((i_req_valid & ~exp_ready) != 0) && (m_stall != 16'hFFFF)) m_stall = m_stall + 16'd1;
    end
    cyc++;
  endtask

  task automatic advance();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic tick();
    sample();
    advance();
  endtask

  task automatic rand_req(input int r);
    int addr, sel;
    if ($urandom_range(0, 9) < 7) begin
      sel = $urandom_range(0, 7);
      if (sel == 0)      addr = $urandom_range(16'h1000, 16'hFFFF);
      else if (sel == 1) addr = 16'h0FFF;
      else if (sel < 5)  addr = $urandom_range(0, 7);
      else               addr = $urandom_range(0, 4095);
      set_req(r, 1, $urandom_range(0, 2) == 0, $urandom_range(0, 3), addr, $urandom_range(0, 255));
    end else begin
      set_req(r, 0, 0, 0, 0, 0);
    end
  endtask

  initial begin
    for (int m = 0; m < 4; m++)
      for (int a = 0; a < 4096; a++) ref_mem[m][a] = init_val(m, a);

    // Reset state.
    @(negedge clk);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Four parallel reads, one per RAM.
    for (int r = 0; r < 4; r++) set_req(r, 1, 0, r, 16'h010, 0);
    sample();
    check("t2_ready", o_req_ready, 4'hF);
    advance();
    i_req_valid = '0;
    sample();
    check("t2_cs", o_ram_cs, 4'hF);
    advance();
    tick();
    sample();
    check("t2_rvalid", o_rvalid, 4'hF);
    check("t2_rdata", o_rdata, {init_val(3, 16), init_val(2, 16), init_val(1, 16), init_val(0, 16)});
    advance();

    // Reset while three reads are in flight.
    for (int r = 0; r < 3; r++) set_req(r, 1, 0, r, 16'h100 + r, 0);
    sample();
    check("t1_issue_ready", o_req_ready, 4'b0111);
    advance();
    i_req_valid = '0;
    rst = 1'b1;
    tick();
    sample();
    check("t1_zero_ready", o_req_ready, 0);
    check("t1_zero_err", o_err, 0);
    check("t1_zero_rvalid", o_rvalid, 0);
    check("t1_zero_rdata", o_rdata, 0);
    check("t1_zero_cs", o_ram_cs, 0);
    check("t1_zero_we", o_ram_we, 0);
    check("t1_zero_addr", o_ram_addr, 0);
    check("t1_zero_din", o_ram_din, 0);
    check("t1_zero_stall", o_stall_cnt, 0);
    advance();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sample();
      check("t1_no_rvalid", o_rvalid, 0);
      advance();
    end

    // Two writes contend for the single write slot, rr_ptr=0.
    set_req(0, 1, 1, 1, 16'h005, 8'h11);
    set_req(2, 1, 1, 3, 16'h006, 8'h22);
    sample();
    check("t3_ready_t", o_req_ready, 4'b0001);
    advance();
    set_req(0, 0, 0, 0, 0, 0);
    sample();
    check("t3_ready_t1", o_req_ready, 4'b0100);
    check("t3_we_t1", o_ram_we, 4'b0010);
    advance();
    set_req(2, 0, 0, 0, 0, 0);
    sample();
    check("t3_we_t2", o_ram_we, 4'b1000);
    advance();

    // Read and write to the same RAM/address, rr_ptr=3: write wins.
    set_req(1, 1, 0, 2, 16'h020, 0);
    set_req(3, 1, 1, 2, 16'h020, 8'hA5);
    sample();
    check("t4_write_first", o_req_ready, 4'b1000);
    advance();
    set_req(3, 0, 0, 0, 0, 0);
    sample();
    check("t4_read_next", o_req_ready, 4'b0010);
    advance();
    set_req(1, 0, 0, 0, 0, 0);
    tick();
    tick();
    sample();
    check("t4_rvalid", o_rvalid, 4'b0010);
    check("t4_rdata", o_rdata[15:8], 8'hA5);
    advance();

    // Address window boundary.
    set_req(0, 1, 0, 0, 16'h0FFF, 0);
    sample();
    check("t5_last_ok_ready", o_req_ready, 4'b0001);
    advance();
    set_req(0, 1, 0, 0, 16'h1000, 0);
    sample();
    check("t5_reject_ready", o_req_ready, 4'b0001);
    check("t5_last_ok_cs", o_ram_cs, 4'b0001);
    advance();
    set_req(0, 0, 0, 0, 0, 0);
    sample();
    check("t5_err_pulse", o_err, 4'b0001);
    check("t5_no_cs", o_ram_cs, 4'b0000);
    advance();
    sample();
    check("t5_err_single", o_err, 4'b0000);
    advance();

    // Random mixed traffic with requesters holding until consumed.
    for (int r = 0; r < 4; r++) rand_req(r);
    for (int c = 0; c < 600; c++) begin
      tick();
      for (int r = 0; r < 4; r++) if (!i_req_valid[r] || last_ready[r]) rand_req(r);
    end
    i_req_valid = '0;
    for (int c = 0; c < 5; c++) tick();

    // Fairness under continuous writes, then counter saturation.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    for (int r = 0; r < 4; r++) begin
      gcount[r] = 0;
      set_req(r, 1, 1, r, $urandom_range(0, 4095), $urandom_range(0, 255));
    end
    for (int c = 0; c < 1000; c++) begin
      sample();
      for (int r = 0; r < 4; r++) if (o_req_ready[r]) gcount[r]++;
      advance();
      for (int r = 0; r < 4; r++)
        if (last_ready[r]) set_req(r, 1, 1, r, $urandom_range(0, 4095), $urandom_range(0, 255));
    end
    for (int r = 0; r < 4; r++) check("t6_fair_share", (gcount[r] >= 249) && (gcount[r] <= 251), 1);
    sample();
    check("t6_stall_1000", o_stall_cnt, 16'd1000);
    advance();
    for (int c = 0; c < 70000; c++) begin
      tick();
      for (int r = 0; r < 4; r++)
        if (last_ready[r]) set_req(r, 1, 1, r, $urandom_range(0, 4095), $urandom_range(0, 255));
    end
    i_req_valid = '0;
    sample();
    check("t6_stall_sat", o_stall_cnt, 16'hFFFF);
    advance();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
